// File: rtl/noc2_vr_packet_arbiter.sv
// -----------------------------------------------------------------------------
// noc2_vr_packet_arbiter
//
// Packet-atomic round-robin arbiter. It merges NUM_SRC val/rdy NoC2 request
// streams into one val/rdy stream that feeds the NoC-to-AXI4 bridge. When a
// header flit wins, the grant stays with that source until the last payload
// flit (header length field) has transferred.
//
// Ports
//   clk       in   core clock
//   reset     in   asynchronous, active-high reset
//   src_val   in   [NUM_SRC]            per-source flit valid
//   src_dat   in   [NUM_SRC*DATA_WIDTH] per-source flit, source i at [i*DATA_WIDTH +: DATA_WIDTH]
//   src_rdy   out  [NUM_SRC]            per-source ready
//   dst_val   out                       merged flit valid
//   dst_dat   out  [DATA_WIDTH]         merged flit
//   dst_rdy   in                        downstream ready
//   busy      out                       packet in progress (grant locked)
//   grant_id  out  [clog2(NUM_SRC)]     currently selected source
//
// Optional build macro: NOC2_ARB_OUT_REG_EN
//   Defined   : 2-entry output skid buffer; 1 cycle latency, src_rdy depends
//               only on buffer occupancy, FSM advances on source->buffer accept.
//   Undefined : zero-latency combinational path from selected source to dst.
//
// State     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | no packet open; round-robin search from rr_ptr for a header
// ST_BUSY   | grant locked to locked_id until remaining payload flits drain
// -----------------------------------------------------------------------------
module noc2_vr_packet_arbiter #(
   parameter int NUM_SRC    = 4,
   parameter int DATA_WIDTH = 64,
   parameter int LEN_MSB    = 29,
   parameter int LEN_LSB    = 22
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_SRC-1:0]            src_val,
   input  logic [NUM_SRC*DATA_WIDTH-1:0] src_dat,
   output logic [NUM_SRC-1:0]            src_rdy,
   output logic                          dst_val,
   output logic [DATA_WIDTH-1:0]         dst_dat,
   input  logic                          dst_rdy,
   output logic                          busy,
   output logic [$clog2(NUM_SRC)-1:0]    grant_id
);

   localparam int ID_W  = $clog2(NUM_SRC);
   localparam int LEN_W = LEN_MSB - LEN_LSB + 1;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]   locked_id_q, locked_id_d;
   logic [LEN_W-1:0]  remaining_q, remaining_d;

   logic [DATA_WIDTH-1:0] flit [NUM_SRC];
   logic [ID_W-1:0]       sel;
   logic                  sel_val;
   logic [DATA_WIDTH-1:0] sel_dat;
   logic [LEN_W-1:0]      hdr_len;
   logic                  out_rdy;   // ready offered to the selected source
   logic                  take;      // selected flit accepted this cycle
   logic                  out_val;
   logic [DATA_WIDTH-1:0] out_dat;
   logic                  found;
   int                    idx;

   function automatic logic [ID_W-1:0] wrap_inc(input logic [ID_W-1:0] v);
      if (v == ID_W'(NUM_SRC - 1)) begin
         return '0;
      end
      return v + ID_W'(1);
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_SRC; i++) begin
         flit[i] = src_dat[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   // Round-robin search starting at rr_ptr; with nothing valid, sel stays at
   // rr_ptr so grant_id reports the pointer.
   always_comb begin
      sel   = rr_ptr_q;
      found = 1'b0;
      idx   = 0;
      if (state_q == ST_BUSY) begin
         sel = locked_id_q;
      end else begin
         for (int k = 0; k < NUM_SRC; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_SRC) begin
               idx = idx - NUM_SRC;
            end
            if (!found && src_val[idx]) begin
               sel   = ID_W'(idx);
               found = 1'b1;
            end
         end
      end
   end

   assign sel_val = src_val[sel];
   assign sel_dat = flit[sel];
   assign hdr_len = sel_dat[LEN_MSB:LEN_LSB];
   assign take    = sel_val & out_rdy;

`ifdef NOC2_ARB_OUT_REG_EN
   logic [DATA_WIDTH-1:0] buf_q [2];
   logic [1:0]            cnt_q;
   logic                  wr_ptr_q;
   logic                  rd_ptr_q;
   logic                  pop;

   assign out_rdy = (cnt_q != 2'd2);
   assign pop     = (cnt_q != 2'd0) & dst_rdy;
   assign out_val = (cnt_q != 2'd0);
   assign out_dat = buf_q[rd_ptr_q];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         buf_q[0] <= '0;
         buf_q[1] <= '0;
         cnt_q    <= 2'd0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         if (take) begin
            buf_q[wr_ptr_q] <= sel_dat;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         case ({take, pop})
            2'b10:   cnt_q <= cnt_q + 2'd1;
            2'b01:   cnt_q <= cnt_q - 2'd1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end
`else
   assign out_rdy = dst_rdy;
   assign out_val = sel_val;
   assign out_dat = sel_dat;
`endif

   // Reset gates the outputs directly so they drop asynchronously even while
   // sources keep presenting valid flits.
   always_comb begin
      src_rdy  = '0;
      dst_val  = 1'b0;
      dst_dat  = '0;
      busy     = 1'b0;
      grant_id = '0;
      if (!reset) begin
         src_rdy[sel] = out_rdy;
         dst_val      = out_val;
         dst_dat      = out_dat;
         busy         = (state_q == ST_BUSY);
         grant_id     = sel;
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      locked_id_d = locked_id_q;
      remaining_d = remaining_q;
      case (state_q)
         ST_IDLE: begin
            if (take) begin
               if (hdr_len == '0) begin
                  rr_ptr_d = wrap_inc(sel);
               end else begin
                  state_d     = ST_BUSY;
                  locked_id_d = sel;
                  remaining_d = hdr_len;
               end
            end
         end
         ST_BUSY: begin
            if (take) begin
               remaining_d = remaining_q - LEN_W'(1);
               if (remaining_q == LEN_W'(1)) begin
                  state_d  = ST_IDLE;
                  rr_ptr_d = wrap_inc(locked_id_q);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         locked_id_q <= '0;
         remaining_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         locked_id_q <= locked_id_d;
         remaining_q <= remaining_d;
      end
   end

endmodule

// File: doc/noc2_vr_packet_arbiter.md
Name: noc2_vr_packet_arbiter

Overview:
- Packet-atomic round-robin arbiter that merges NUM_SRC val/rdy NoC2 request streams into one val/rdy stream.
- Sits between several credit_to_valrdy converters and the single NoC2 input of the NoC-to-AXI4 bridge, so multiple chips or tiles share one AXI master port.
- Once a header flit wins, the arbiter holds the grant until the packet's last payload flit has transferred.

Parameters:
- NUM_SRC, 4, number of requesting sources (2..8).
- DATA_WIDTH, 64, flit width; equals NOC_DATA_WIDTH.
- LEN_MSB, 29, MSB of the header payload-length field.
- LEN_LSB, 22, LSB of the header payload-length field (8 bits).

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- src_val  in  NUM_SRC  per-source flit valid.
- src_dat  in  NUM_SRC*DATA_WIDTH  per-source flit; source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- src_rdy  out  NUM_SRC  per-source ready.
- dst_val  out  1  merged flit valid.
- dst_dat  out  DATA_WIDTH  merged flit.
- dst_rdy  in  1  downstream ready.
- busy  out  1  a packet is in progress (locked).
- grant_id  out  clog2(NUM_SRC)  currently selected source index.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- A transfer occurs on any cycle where valid and ready are both 1.
- Reset state: IDLE, rr_ptr=0, remaining=0, locked_id=0.
- While reset is asserted, src_rdy=0, dst_val=0, dst_dat=0, busy=0, grant_id=0.
- State IDLE:
  - sel = first i with src_val[i]=1, scanning rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_SRC.
  - If no source is valid: dst_val=0 and grant_id=rr_ptr.
  - dst_val = src_val[sel]; dst_dat = src_dat[sel]; src_rdy[sel] = dst_rdy; all other src_rdy = 0.
  - Header handshake with len = dst_dat[LEN_MSB:LEN_LSB]:
    - len==0: stay IDLE; rr_ptr <= sel+1 (mod NUM_SRC).
    - len>0: go BUSY; locked_id <= sel; remaining <= len.
  - The selection may change between cycles while the header is not accepted; no commitment before the handshake.
- State BUSY:
  - sel = locked_id; busy=1; other sources see rdy=0 even when valid.
  - Each handshake decrements remaining.
  - On the handshake with remaining==1: go IDLE; rr_ptr <= locked_id+1 (mod NUM_SRC).
  - src_val low mid-packet (bubble): hold the lock; no timeout.
- Latency: 0 cycles; dst is combinational from the selected source. Full throughput, 1 flit/cycle, including back-to-back packets from different sources.
- Widths: remaining is 8 bits; maximum packet is 1 header + 255 payload flits. rr_ptr wraps from NUM_SRC-1 to 0.
- Backpressure: dst_rdy=0 blocks all src_rdy; state is unchanged.
- Reset mid-packet: the lock is dropped immediately. Any partial packet already forwarded is not recovered; upstream and downstream are reset together.
- No flit is ever duplicated or reordered within a source.

Optional Feature:
- Macro: NOC2_ARB_OUT_REG_EN.
- When defined: a 2-entry output skid buffer registers dst_val/dst_dat.
  - Latency is 1 cycle; throughput stays 1 flit/cycle.
  - src_rdy depends only on the buffer not being full, not on dst_rdy combinationally.
  - The arbiter FSM advances on the source-to-buffer handshake.
  - Reset empties the buffer; dst_val=0.
- When undefined: zero-latency combinational path as described above.

Test Plan:
1. Only src 0 sends a header with len=2 plus 2 payload flits, dst_rdy=1 → 3 consecutive dst flits, identical data. busy=1 from the cycle after the header until the last flit transfers. rr_ptr=1 afterwards.
2. src 1 and src 2 each send a 3-flit packet (len=2), both valid in the same cycle, rr_ptr=0 → src 1 is fully forwarded first, then src 2. No interleaving; src_rdy[2]=0 throughout src 1's packet. Final rr_ptr=3.
3. All 4 sources continuously send len=0 single-flit packets → grant sequence 0,1,2,3,0,... one flit per cycle.
4. dst_rdy toggles 1,0,1,0 during src 3's len=4 packet; src 0 is also valid → all 5 flits of src 3 arrive in order. src 0 is blocked until the last flit of src 3, then granted.
5. Assert reset after 2 of 5 flits of src 1 → outputs go to 0 asynchronously. After release: IDLE, rr_ptr=0, src 0's new header is granted.
6. Header with len=255 from src 2 → exactly 256 flits are forwarded before the lock is released; the counter does not wrap early.
